// File: rtl/adc_lane_frame_align_pkg.sv
// Shared types and width helpers for the ADC lane frame aligner.
package adc_align_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        VERIFY,
        LOCKED
    } align_state_e;

    localparam int DEF_BITS = 8;
    localparam int OFS_W    = $clog2(DEF_BITS);
    localparam int LOSS_W   = 16;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of a bit offset 0..bits-1, never narrower than one bit.
    function automatic int ofs_w(input int bits);
        return (bits < 2) ? 1 : $clog2(bits);
    endfunction

endpackage

// File: rtl/adc_lane_frame_align_window.sv
// One lane's word window: keeps the previous valid word and selects
// BITS bits out of {prev, cur} starting at the shared bit offset.
module adc_word_window
    import adc_align_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int OW   = OFS_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [BITS-1:0] din,
    input  logic [OW-1:0]   offset,
    output logic [BITS-1:0] dout
);

    logic [BITS-1:0]   prev_q;
    logic [BITS-1:0]   prev_d;
    logic [2*BITS-1:0] combined;

    always_comb begin
        prev_d   = valid ? din : prev_q;
        combined = {prev_q, din};
        dout     = combined[offset +: BITS];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/adc_lane_frame_align.sv
// Word-boundary alignment for deserialised ADC lanes: searches the frame
// lane for FRAME_PATTERN and applies the found bit offset to every lane.
module adc_lane_frame_align
    import adc_align_pkg::*;
#(
    parameter int              NUM_LANES     = 10,
    parameter int              BITS          = 8,
    parameter logic [BITS-1:0] FRAME_PATTERN = 8'hF0,
    parameter int              LOCK_COUNT    = 16,
    parameter int              SLIP_SETTLE   = 4,
    localparam int             OW            = ofs_w(BITS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      din_valid,
    input  logic [NUM_LANES*BITS-1:0] din,
    input  logic [BITS-1:0]           frame_in,
    input  logic                      realign,
    output logic [NUM_LANES*BITS-1:0] dout,
    output logic                      dout_valid,
    output logic [OW-1:0]             slip_offset,
    output logic                      locked,
    output logic                      lock_err,
    output logic [LOSS_W-1:0]         lock_loss_cnt
);

    localparam int MW  = cnt_w(LOCK_COUNT);
    localparam int SWW = cnt_w(BITS);
    localparam int STW = cnt_w(SLIP_SETTLE);
    localparam int SETTLE_LAST = (SLIP_SETTLE > 0) ? SLIP_SETTLE - 1 : 0;

    align_state_e              state_q, state_d;
    logic [OW-1:0]             ofs_q, ofs_d;
    logic [STW-1:0]            settle_q, settle_d;
    logic [MW-1:0]             match_q, match_d;
    logic [SWW-1:0]            sweep_q, sweep_d;
    logic                      err_q, err_d;
    logic [LOSS_W-1:0]         loss_q, loss_d;
    logic                      locked_q, locked_d;
    logic                      dvld_q, dvld_d;
    logic [NUM_LANES*BITS-1:0] dout_q, dout_d;
    logic [NUM_LANES*BITS-1:0] aligned_lanes;
    logic [BITS-1:0]           aligned_frame;
    logic                      frame_hit;

    adc_word_window #(.BITS(BITS), .OW(OW)) u_frame_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (din_valid),
        .din    (frame_in),
        .offset (ofs_q),
        .dout   (aligned_frame)
    );

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        adc_word_window #(.BITS(BITS), .OW(OW)) u_lane_win (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid  (din_valid),
            .din    (din[i*BITS +: BITS]),
            .offset (ofs_q),
            .dout   (aligned_lanes[i*BITS +: BITS])
        );
    end

    always_comb begin
        state_d   = state_q;
        ofs_d     = ofs_q;
        settle_d  = settle_q;
        match_d   = match_q;
        sweep_d   = sweep_q;
        err_d     = err_q;
        loss_d    = loss_q;
        frame_hit = (aligned_frame == FRAME_PATTERN);

        if (realign) begin
            state_d  = SEARCH;
            ofs_d    = '0;
            settle_d = '0;
            match_d  = '0;
            sweep_d  = '0;
            err_d    = 1'b0;
        end else if (din_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (frame_hit) begin
                        match_d = MW'(1);
                        sweep_d = '0;
                        state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end else begin
                        ofs_d = (ofs_q == OW'(BITS - 1)) ? '0 : ofs_q + 1'b1;
                        // A full sweep without a hit flags the error and starts a new sweep.
                        if (sweep_q == SWW'(BITS - 1)) begin
                            err_d   = 1'b1;
                            sweep_d = '0;
                        end else begin
                            sweep_d = sweep_q + 1'b1;
                        end
                        settle_d = '0;
                        state_d  = (SLIP_SETTLE == 0) ? SEARCH : SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == STW'(SETTLE_LAST)) begin
                        settle_d = '0;
                        state_d  = SEARCH;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                VERIFY: begin
                    if (frame_hit) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (!frame_hit) begin
                        match_d = '0;
                        state_d = SEARCH;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
        dvld_d   = din_valid && (state_d == LOCKED);
        dout_d   = din_valid ? aligned_lanes : dout_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            ofs_q    <= '0;
            settle_q <= '0;
            match_q  <= '0;
            sweep_q  <= '0;
            err_q    <= 1'b0;
            loss_q   <= '0;
            locked_q <= 1'b0;
            dvld_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            ofs_q    <= ofs_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            sweep_q  <= sweep_d;
            err_q    <= err_d;
            loss_q   <= loss_d;
            locked_q <= locked_d;
            dvld_q   <= dvld_d;
            dout_q   <= dout_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dvld_q;
    assign slip_offset   = ofs_q;
    assign locked        = locked_q;
    assign lock_err      = err_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_adc_lane_frame_align.sv
// Bench for adc_lane_frame_align: directed scenarios plus a random soak,
// all checked against a word-level behavioural model of the aligner.
module tb_adc_lane_frame_align;

    localparam int        NL = 10;
    localparam int        B  = 8;
    localparam int        W  = NL * B;
    localparam logic [7:0] FP = 8'hF0;
    localparam int        LC = 16;
    localparam int        SS = 4;

    localparam int P_SEARCH = 0;
    localparam int P_SETTLE = 1;
    localparam int P_VERIFY = 2;
    localparam int P_LOCKED = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic [B-1:0] frame_in = '0;
    logic         realign = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic [2:0]   slip_offset;
    logic         locked;
    logic         lock_err;
    logic [15:0]  lock_loss_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int           m_phase, m_ofs, m_settle, m_match, m_sweep, m_loss;
    bit           m_err, m_locked, m_dvld;
    logic [W-1:0] m_dout;
    logic [7:0]   m_prev [0:NL];
    int           base [0:NL-1];
    logic [7:0]   fr_del;

    adc_lane_frame_align #(
        .NUM_LANES     (NL),
        .BITS          (B),
        .FRAME_PATTERN (FP),
        .LOCK_COUNT    (LC),
        .SLIP_SETTLE   (SS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_valid     (din_valid),
        .din           (din),
        .frame_in      (frame_in),
        .realign       (realign),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .slip_offset   (slip_offset),
        .locked        (locked),
        .lock_err      (lock_err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word seen at bit offset k of the two-word stream {p, c}.
    function automatic logic [7:0] win(input logic [7:0] p, input logic [7:0] c, input int k);
        logic [15:0] s;
        s = {p, c} >> k;
        return s[7:0];
    endfunction

    function automatic logic [W-1:0] rnd_lanes();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Lane counters as transmitted, not yet shifted.
    function automatic logic [W-1:0] lanes_clean(input int t);
        logic [W-1:0] v;
        for (int i = 0; i < NL; i++) v[i*B +: B] = 8'((base[i] + t) & 255);
        return v;
    endfunction

    // Lane counters as received, with the word boundary 3 bits late.
    function automatic logic [W-1:0] lanes_delayed(input int t);
        logic [W-1:0] v;
        int c0, c1;
        for (int i = 0; i < NL; i++) begin
            c0 = (base[i] + t) & 255;
            c1 = (base[i] + t + 1) & 255;
            v[i*B +: B] = 8'(((c0 & 31) << 3) | (c1 >> 5));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_phase = P_SEARCH; m_ofs = 0; m_settle = 0; m_match = 0; m_sweep = 0;
        m_loss = 0; m_err = 0; m_locked = 0; m_dvld = 0; m_dout = '0;
        for (int i = 0; i <= NL; i++) m_prev[i] = 8'h00;
    endtask

    // Apply one clock of stimulus, advance the model, then compare all outputs.
    task automatic step(input bit v, input bit ra, input bit rn, input logic [7:0] fr,
                        input logic [W-1:0] d);
        bit hit;
        din_valid = v; realign = ra; rst_n = rn; frame_in = fr; din = d;
        if (!rn) begin
            model_reset();
        end else begin
            hit = (win(m_prev[NL], fr, m_ofs) == FP);
            if (v) for (int i = 0; i < NL; i++) m_dout[i*B +: B] = win(m_prev[i], d[i*B +: B], m_ofs);
            if (ra) begin
                m_phase = P_SEARCH; m_ofs = 0; m_settle = 0; m_match = 0; m_sweep = 0; m_err = 0;
            end else if (v) begin
                case (m_phase)
                    P_SEARCH: if (hit) begin
                        m_match = 1; m_sweep = 0;
                        m_phase = (LC == 1) ? P_LOCKED : P_VERIFY;
                    end else begin
                        m_ofs = (m_ofs + 1) % B;
                        m_sweep++;
                        if (m_sweep == B) begin m_err = 1; m_sweep = 0; end
                        m_settle = 0;
                        m_phase = (SS == 0) ? P_SEARCH : P_SETTLE;
                    end
                    P_SETTLE: begin
                        m_settle++;
                        if (m_settle == SS) begin m_settle = 0; m_phase = P_SEARCH; end
                    end
                    P_VERIFY: if (hit) begin
                        m_match++;
                        if (m_match == LC) m_phase = P_LOCKED;
                    end else begin
                        m_match = 0; m_phase = P_SEARCH;
                    end
                    default: if (!hit) begin
                        m_match = 0; m_phase = P_SEARCH;
                        if (m_loss < 65535) m_loss++;
                    end
                endcase
            end
            m_locked = (m_phase == P_LOCKED);
            m_dvld   = v && (m_phase == P_LOCKED);
            if (v) begin
                for (int i = 0; i < NL; i++) m_prev[i] = d[i*B +: B];
                m_prev[NL] = fr;
            end
        end
        @(posedge clk);
        #1;
        chk("dout", dout, m_dout);
        chk("dout_valid", W'(dout_valid), W'(m_dvld));
        chk("slip_offset", W'(slip_offset), W'(m_ofs));
        chk("locked", W'(locked), W'(m_locked));
        chk("lock_err", W'(lock_err), W'(m_err));
        chk("lock_loss_cnt", W'(lock_loss_cnt), W'(m_loss));
    endtask

    initial begin
        int first_lock, first_dv, first_err, vcount, any_lock;
        fr_del = {FP[4:0], FP[7:5]};
        for (int i = 0; i < NL; i++) base[i] = int'($urandom_range(0, 255));
        model_reset();

        // Reset values
        step(1'b0, 1'b0, 1'b0, 8'h00, '0);
        step(1'b1, 1'b0, 1'b0, 8'h5A, rnd_lanes());
        chk("rst_dout", dout, '0);
        chk("rst_dout_valid", W'(dout_valid), '0);
        chk("rst_slip_offset", W'(slip_offset), '0);
        chk("rst_locked", W'(locked), '0);
        chk("rst_lock_err", W'(lock_err), '0);
        chk("rst_loss", W'(lock_loss_cnt), '0);

        // Frame lane three bits late, lanes carry counters
        first_lock = 0; first_dv = 0;
        for (int t = 0; t < 40; t++) begin
            step(1'b1, 1'b0, 1'b1, fr_del, lanes_delayed(t));
            if (locked && first_lock == 0) first_lock = t + 1;
            if (dout_valid && first_dv == 0) first_dv = t + 1;
        end
        chk("c1_lock_words", W'(first_lock), W'(31));
        chk("c1_first_dv", W'(first_dv), W'(31));
        chk("c1_offset", W'(slip_offset), W'(3));
        chk("c1_dout_counter", dout, lanes_clean(39));

        // One corrupted frame word while locked, then relock at the same offset
        step(1'b1, 1'b0, 1'b1, fr_del ^ 8'h80, lanes_delayed(40));
        chk("c4_unlocked", W'(locked), '0);
        chk("c4_loss", W'(lock_loss_cnt), W'(1));
        chk("c4_offset", W'(slip_offset), W'(3));
        first_lock = 0;
        for (int t = 41; t < 60; t++) begin
            step(1'b1, 1'b0, 1'b1, fr_del, lanes_delayed(t));
            if (locked && first_lock == 0) first_lock = t - 40;
        end
        chk("c4_relock_words", W'(first_lock), W'(16));
        chk("c4_relock_offset", W'(slip_offset), W'(3));

        // Frame lane stuck at zero: full sweep, wrap, sticky error, realign clears
        step(1'b1, 1'b0, 1'b0, 8'h00, '0);
        first_err = 0; any_lock = 0;
        for (int t = 0; t < 40; t++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00, rnd_lanes());
            if (lock_err && first_err == 0) first_err = t + 1;
            if (locked) any_lock = 1;
            if (t == 30) chk("c3_offset_7", W'(slip_offset), W'(7));
            if (t == 35) chk("c3_offset_wrap", W'(slip_offset), W'(0));
        end
        chk("c3_err_words", W'(first_err), W'(36));
        chk("c3_never_locked", W'(any_lock), '0);
        step(1'b1, 1'b1, 1'b1, 8'h00, rnd_lanes());
        chk("c3_realign_err", W'(lock_err), '0);
        chk("c3_realign_offset", W'(slip_offset), '0);

        // Already aligned stream
        step(1'b1, 1'b0, 1'b0, 8'h00, '0);
        first_lock = 0; first_dv = 0; any_lock = 0;
        for (int t = 0; t < 20; t++) begin
            step(1'b1, 1'b0, 1'b1, FP, rnd_lanes());
            if (locked && first_lock == 0) first_lock = t + 1;
            if (dout_valid && first_dv == 0) first_dv = t + 1;
            if (slip_offset != 3'd0) any_lock = 1;
        end
        chk("c2_lock_words", W'(first_lock), W'(16));
        chk("c2_first_dv", W'(first_dv), W'(16));
        chk("c2_no_slip", W'(any_lock), '0);
        chk("c2_loss", W'(lock_loss_cnt), '0);

        // din_valid toggling during search
        step(1'b1, 1'b0, 1'b0, 8'h00, '0);
        first_lock = 0; vcount = 0;
        for (int t = 0; t < 80; t++) begin
            if (t % 2 == 0) begin
                step(1'b1, 1'b0, 1'b1, fr_del, lanes_delayed(vcount));
                vcount++;
            end else begin
                step(1'b0, 1'b0, 1'b1, 8'($urandom()), rnd_lanes());
            end
            if (locked && first_lock == 0) first_lock = vcount;
        end
        chk("c5_lock_valid_words", W'(first_lock), W'(31));
        chk("c5_offset", W'(slip_offset), W'(3));

        // Reset while verifying
        step(1'b1, 1'b0, 1'b0, 8'h00, '0);
        for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 1'b1, FP, rnd_lanes());
        step(1'b1, 1'b0, 1'b0, FP, rnd_lanes());
        chk("c6_dout", dout, '0);
        chk("c6_locked", W'(locked), '0);
        chk("c6_offset", W'(slip_offset), '0);
        chk("c6_dout_valid", W'(dout_valid), '0);
        step(1'b1, 1'b0, 1'b1, fr_del, rnd_lanes());
        chk("c6_restart_slip", W'(slip_offset), W'(1));

        // Random soak: gaps, occasional corrupted frames and realign requests
        step(1'b1, 1'b0, 1'b0, 8'h00, '0);
        for (int t = 0; t < 400; t++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 1'b1,
                 ($urandom_range(0, 29) == 0) ? (fr_del ^ 8'(1 << $urandom_range(3, 7))) : fr_del,
                 rnd_lanes());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
